// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
//   Multi-cycle Nios II custom-instruction controller that sequences a
//   dot-product job through one external MAC pipeline. Software PUSHes
//   weight/input pairs into an operand buffer, then issues RUN. Each pair is
//   issued with the previous partial sum on mac_o_o, and the final fp32 sum is
//   returned on result. No arithmetic is done here; words pass through raw.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   clk_en         custom-instruction clock enable (qualifies all updates)
//   start, n       instruction start / opcode (0 PUSH, 1 RUN, 2 CLEAR, 3 STATUS)
//   dataa, datab   PUSH operands: weight word, input word
//   done, result   one-cycle completion pulse, instruction result (held)
//   mac_nop_o      to MAC NOPIn (0 = operands valid this cycle)
//   mac_w_o/i_o/o_o  to MAC W_Data / I_Data / O_Data (running partial sum)
//   mac_nop_i      from MAC NOPOut (0 = mac_data_i valid)
//   mac_data_i     from MAC DataOut
module mac_seq_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic        mac_nop_o,
  output logic [31:0] mac_w_o,
  output logic [31:0] mac_i_o,
  output logic [31:0] mac_o_o,
  input  logic        mac_nop_i,
  input  logic [31:0] mac_data_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [1:0] OP_PUSH   = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_STATUS = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] k;
  logic [TW-1:0] wcnt;
  logic [31:0]   acc;
  logic          err;

  logic [63:0]   mem [DEPTH];

  logic [CW-1:0] count_inc;
  logic [CW-1:0] k_nxt;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_pair;
  logic          push_wr;

  always_comb begin
    count_inc = count + 1'b1;
    k_nxt     = k + 1'b1;
    // The pair for the next ISSUE is read combinationally on the edge that
    // enters ISSUE: pair 0 from IDLE, pair k+1 from WAIT.
    rd_addr   = (state == S_IDLE) ? '0 : k_nxt[AW-1:0];
    rd_pair   = mem[rd_addr];
    push_wr   = clk_en && (state == S_IDLE) && start && (n == OP_PUSH) && (count != FULL);
  end

  // Buffer contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clk) begin
    if (!reset && push_wr) begin
      mem[count[AW-1:0]] <= {dataa, datab};
    end
  end

  // The partial sum register drives O_Data directly; it only changes in
  // cycles where the MAC ignores O_Data, so no separate output copy is needed.
  assign mac_o_o = acc;

  // done is gated by clk_en so a stalled FIN cycle does not count as the pulse.
  assign done = clk_en && (state == S_FIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      k         <= '0;
      wcnt      <= '0;
      acc       <= '0;
      err       <= 1'b0;
      result    <= '0;
      mac_nop_o <= 1'b1;
      mac_w_o   <= '0;
      mac_i_o   <= '0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (n)
              OP_PUSH: begin
                if (count != FULL) begin
                  count  <= count_inc;
                  result <= 32'(count_inc);
                end else begin
                  result <= 32'(count);
                end
                state <= S_FIN;
              end
              OP_RUN: begin
                acc <= '0;
                err <= 1'b0;
                k   <= '0;
                if (count == '0) begin
                  result <= '0;
                  state  <= S_FIN;
                end else begin
                  mac_nop_o <= 1'b0;
                  mac_w_o   <= rd_pair[63:32];
                  mac_i_o   <= rd_pair[31:0];
                  state     <= S_ISSUE;
                end
              end
              OP_CLEAR: begin
                count  <= '0;
                acc    <= '0;
                err    <= 1'b0;
                result <= '0;
                state  <= S_FIN;
              end
              default: begin
                result <= {err, 15'b0, 16'(count)};
                state  <= S_FIN;
              end
            endcase
          end
        end

        S_ISSUE: begin
          mac_nop_o <= 1'b1;
          wcnt      <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          if (!mac_nop_i) begin
            acc <= mac_data_i;
            k   <= k_nxt;
            if (k_nxt == count) begin
              result <= mac_data_i;
              state  <= S_FIN;
            end else begin
              mac_nop_o <= 1'b0;
              mac_w_o   <= rd_pair[63:32];
              mac_i_o   <= rd_pair[31:0];
              state     <= S_ISSUE;
            end
          end else if (wcnt == WAIT_MAX) begin
            err    <= 1'b1;
            result <= QNAN;
            state  <= S_FIN;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: directed instructions with hand-computed
// results and completion latencies, a behavioural fp32 MAC (latency 4,
// O + W*I), and a scoreboard queue drained by an independent done monitor.
module tb_mac_seq_ctrl;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 64;
  localparam int          L       = 4;

  localparam logic [1:0] OP_PUSH   = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_STATUS = 2'd3;

  localparam logic [31:0] F_1 = 32'h3F80_0000;
  localparam logic [31:0] F_2 = 32'h4000_0000;
  localparam logic [31:0] F_3 = 32'h4040_0000;
  localparam logic [31:0] F_5 = 32'h40A0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [1:0]  n;
  logic [31:0] dataa, datab;
  logic        done;
  logic [31:0] result;
  logic        mac_nop_o;
  logic [31:0] mac_w_o, mac_i_o, mac_o_o;
  logic        mac_nop_i;
  logic [31:0] mac_data_i;

  mac_seq_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .start      (start),
    .n          (n),
    .dataa      (dataa),
    .datab      (datab),
    .done       (done),
    .result     (result),
    .mac_nop_o  (mac_nop_o),
    .mac_w_o    (mac_w_o),
    .mac_i_o    (mac_i_o),
    .mac_o_o    (mac_o_o),
    .mac_nop_i  (mac_nop_i),
    .mac_data_i (mac_data_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  int nop_pulses  = 0;

  // ---------------- behavioural MAC ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic        mac_dead = 1'b0;
  logic        pv [L];
  logic [31:0] pd [L];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) pv[i] <= 1'b0;
    end else if (clk_en) begin
      for (int i = L - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= !mac_nop_o;
      pd[0] <= r2f(f2r(mac_o_o) + f2r(mac_w_o) * f2r(mac_i_o));
    end
  end

  assign mac_nop_i  = mac_dead ? 1'b1 : !pv[L-1];
  assign mac_data_i = pd[L-1];

  // ---------------- scoreboard ----------------
  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (!mac_nop_o) nop_pulses++;
    if (done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 result=%h at cycle %0d, required no done", result, cyc);
      end else begin
        e = sb.pop_front();
        vectors++;
        if (result !== e.res) begin
          miscompares++;
          $display("FAIL %s_result: got %h required %h", e.tag, result, e.res);
        end
        vectors++;
        if (cyc - e.t0 != e.lat) begin
          miscompares++;
          $display("FAIL %s_latency: got %0d required %0d", e.tag, cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", tag, got, req);
    end
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat,
                       input bit track);
    @(negedge clk);
    start = 1'b1;
    n     = op;
    dataa = a;
    datab = b;
    if (track) sb.push_back('{tag, res, lat, cyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_no_done: got %0d pending, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic op(input string tag, input logic [1:0] opc, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] res, input int lat);
    issue(tag, opc, a, b, res, lat, 1'b1);
    wait_idle(tag);
  endtask

  int p0;

  initial begin
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = '0; dataa = '0; datab = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_nop", 32'(mac_nop_o), 32'd1);
    chk("reset_w", mac_w_o, 32'd0);
    chk("reset_o", mac_o_o, 32'd0);
    reset = 1'b0;

    op("status0", OP_STATUS, '0, '0, 32'h0000_0000, 1);
    chk("no_issue_before_run", 32'(nop_pulses), 32'd0);

    // two-pair job: 2*5 + 1*3 = 13.0
    op("push_a", OP_PUSH, F_2, F_5, 32'd1, 1);
    op("push_b", OP_PUSH, F_1, F_3, 32'd2, 1);
    op("run2", OP_RUN, '0, '0, 32'h4150_0000, 11);
    op("status2", OP_STATUS, '0, '0, 32'h0000_0002, 1);
    op("rerun2", OP_RUN, '0, '0, 32'h4150_0000, 11);

    // clk_en stalled 5 cycles inside WAIT, plus a stray CLEAR start mid-run
    issue("run_stall", OP_RUN, '0, '0, 32'h4150_0000, 16, 1'b1);
    repeat (2) @(negedge clk);
    clk_en = 1'b0;
    repeat (5) @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    start = 1'b1; n = OP_CLEAR;
    @(negedge clk);
    start = 1'b0;
    wait_idle("run_stall");
    op("status_after_stray", OP_STATUS, '0, '0, 32'h0000_0002, 1);

    // reset mid-run: job aborted, no done, buffer count cleared
    issue("run_abort", OP_RUN, '0, '0, '0, 0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_nop", 32'(mac_nop_o), 32'd1);
    repeat (20) @(negedge clk);
    op("status_after_abort", OP_STATUS, '0, '0, 32'h0000_0000, 1);

    // empty run: immediate done, no MAC issue
    op("clear0", OP_CLEAR, '0, '0, 32'd0, 1);
    p0 = nop_pulses;
    op("run_empty", OP_RUN, '0, '0, 32'd0, 1);
    chk("run_empty_no_issue", 32'(nop_pulses), 32'(p0));

    // fill past capacity with (1.0,1.0), then sum DEPTH ones = 16.0
    for (int i = 1; i <= DEPTH; i++) op("push_fill", OP_PUSH, F_1, F_1, 32'(i), 1);
    op("push_over", OP_PUSH, F_2, F_2, 32'(DEPTH), 1);
    op("status_full", OP_STATUS, '0, '0, 32'(DEPTH), 1);
    op("run_full", OP_RUN, '0, '0, 32'h4180_0000, DEPTH * (L + 1) + 1);

    // MAC never answers: timeout with qNaN and sticky error bit
    op("clear1", OP_CLEAR, '0, '0, 32'd0, 1);
    op("push_t", OP_PUSH, F_2, F_5, 32'd1, 1);
    mac_dead = 1'b1;
    op("run_timeout", OP_RUN, '0, '0, 32'h7FC0_0000, TIMEOUT + 2);
    mac_dead = 1'b0;
    op("status_err", OP_STATUS, '0, '0, 32'h8000_0001, 1);
    op("clear_err", OP_CLEAR, '0, '0, 32'd0, 1);
    op("status_clr", OP_STATUS, '0, '0, 32'h0000_0000, 1);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Multi-cycle Nios II custom-instruction controller that owns one MAC_Pipeline instance and sequences dot-product jobs through it. Software pushes weight/input pairs into an internal operand buffer, then issues RUN. The controller streams the pairs through the MAC, feeding each partial sum back as the O_Data operand, and returns the final IEEE-754 single-precision sum on result. It replaces the fixed-operand single-shot wrapper in the PE group.

Parameters:
DEPTH, 16, number of weight/input pairs the buffer holds (power of two, 2..256)
TIMEOUT, 64, maximum cycles spent waiting for one MAC result before the job aborts
AW, $clog2(DEPTH), buffer address width (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clk_en  in  1  custom-instruction clock enable; all state updates qualified by it, except reset
start  in  1  custom-instruction start, sampled only in IDLE
n  in  2  opcode: 0 PUSH, 1 RUN, 2 CLEAR, 3 STATUS
dataa  in  32  PUSH: weight word (fp32)
datab  in  32  PUSH: input word (fp32)
done  out  1  one-cycle completion pulse
result  out  32  instruction result; valid when done=1, then held
mac_nop_o  out  1  to MAC NOPIn; 0 = issue operands this cycle
mac_w_o  out  32  to MAC W_Data
mac_i_o  out  32  to MAC I_Data
mac_o_o  out  32  to MAC O_Data (running partial sum)
mac_nop_i  in  1  from MAC NOPOut; 0 = mac_data_i valid
mac_data_i  in  32  from MAC DataOut

Behaviour:
- Reset (synchronous, overrides clk_en): state=IDLE, count=0, k=0, acc=0, err=0, done=0, result=0, mac_nop_o=1, mac_w_o/mac_i_o/mac_o_o=0, buffer contents don't-care.
- clk_en=0: all registers hold; done is not asserted. The MAC shares clk_en, so it freezes in lockstep.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE, start=1, n=0 PUSH: if count<DEPTH, write {dataa,datab} at address count and increment count; if full, no write. FIN next cycle with result={16'b0,count_after}, zero-extended.
- IDLE, start=1, n=2 CLEAR: count=0, acc=0, err=0. FIN with result=0.
- IDLE, start=1, n=3 STATUS: FIN with result={err,15'b0,16-bit count}. State is unchanged.
- IDLE, start=1, n=1 RUN: acc=0, err=0, k=0. If count=0, go to FIN with result=0. Otherwise go to ISSUE.
- ISSUE (one cycle): mac_nop_o=0, mac_w_o=W[k], mac_i_o=I[k], mac_o_o=acc. Clear the wait counter, then go to WAIT.
- WAIT: mac_nop_o=1.
  - When mac_nop_i=0: acc=mac_data_i, k=k+1. If k+1=count, go to FIN with result=mac_data_i; else go to ISSUE.
  - If the wait counter reaches TIMEOUT with no valid: err=1, result=32'h7FC00000 (qNaN), go to FIN.
- FIN: done=1 for exactly one clk_en-qualified cycle, then IDLE.
- Timing: with MAC latency L, issue k occurs at cycle 1+k(L+1), and capture k at (k+1)(L+1). done asserts at cycle N(L+1)+1 after the RUN start cycle. PUSH, CLEAR and STATUS complete with done at cycle 1.
- Only one MAC operation is in flight at a time, by construction. The buffer is preserved across RUN, so RUN may be repeated.
- start while not IDLE is ignored. mac_nop_i=0 outside WAIT is ignored.
- Reset mid-RUN aborts the job: no done, count=0. The MAC is reset by the same reset.
- The controller performs no arithmetic on data. All values are passed as raw 32-bit fp words.

Test Plan:
- Reset, then STATUS -> done at cycle 1, result=0x00000000. mac_nop_o=1 throughout.
- PUSH (0x40000000,0x40a00000), PUSH (0x3F800000,0x40400000), RUN, with a bench MAC of latency L=4 computing O+W*I -> done at cycle 11, result=0x41500000 (13.0). STATUS returns 0x00000002.
- DEPTH+1 PUSHes -> last PUSH result=DEPTH, count stays DEPTH. RUN of all-(1.0,1.0) pairs returns the fp32 of DEPTH (16.0 = 0x41800000).
- RUN with count=0 -> done at cycle 1, result=0. No mac_nop_o=0 pulse.
- Bench MAC never drops NOPOut -> done at TIMEOUT+2 cycles, result=0x7FC00000. STATUS bit31=1; CLEAR clears it.
- clk_en low for 5 cycles mid-WAIT, and start pulsed mid-RUN -> completion time shifts by exactly 5 cycles, result unchanged, extra start ignored. Assert reset mid-RUN -> no done pulse, STATUS=0.
